// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the dmem port arbiter and its surroundings: the
// processor memory stage, the auxiliary requester and the dmem itself.
//
// Aux handshake: aux_req is raised together with stable aux_addr,
// aux_wren and aux_data, and all four are held until aux_gnt is sampled
// high at a rising edge. The access happens in the cycle aux_gnt is high.
// The requester may drop aux_req or present the next request in the
// following cycle, so grants can occur back to back.
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   // processor memory stage
   logic              proc_mem_en;
   logic [ADDR_W-1:0] proc_addr;
   logic [DATA_W-1:0] proc_data;
   logic              proc_wren;
   logic [DATA_W-1:0] proc_q;
   // auxiliary requester
   logic              aux_req;
   logic [ADDR_W-1:0] aux_addr;
   logic              aux_wren;
   logic [DATA_W-1:0] aux_data;
   logic              aux_gnt;
   logic              aux_rd_valid;
   logic [DATA_W-1:0] aux_rd_data;
   logic              aux_err;
   logic              aux_starve;
   // dmem side
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_q;

   // agents and dmem side
   modport master (
      output proc_mem_en, proc_addr, proc_data, proc_wren,
      output aux_req, aux_addr, aux_wren, aux_data,
      output mem_q,
      input  proc_q, aux_gnt, aux_rd_valid, aux_rd_data, aux_err, aux_starve,
      input  mem_addr, mem_data, mem_wren
   );

   // arbiter side
   modport slave (
      input  proc_mem_en, proc_addr, proc_data, proc_wren,
      input  aux_req, aux_addr, aux_wren, aux_data,
      input  mem_q,
      output proc_q, aux_gnt, aux_rd_valid, aux_rd_data, aux_err, aux_starve,
      output mem_addr, mem_data, mem_wren
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port dmem between the processor memory stage and one
// auxiliary requester. The processor cannot stall, so it always owns the
// port when it has a memory op; the aux agent only gets idle cycles.
// A saturating counter of consecutive denied cycles raises aux_starve.
// CNT_W must be wide enough that 2**CNT_W-1 >= STARVE_LIMIT.
module dmem_port_arbiter #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 64,
   parameter int CNT_W        = 8,
   parameter bit AUX_WR_EN    = 1'b1
) (
   input logic                  clock,
   input logic                  reset,
   dmem_port_arbiter_if.slave   bus
);

   logic              aux_gnt_c;
   logic [ADDR_W-1:0] addr_mux;
   logic [DATA_W-1:0] data_mux;
   logic              wren_mux;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  starve_cnt_next;
   logic              rd_valid_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              err_q;
   logic              starve_q;

   // Grant only idle cycles; reset forces the grant low.
   always_comb begin
      aux_gnt_c = bus.aux_req & ~bus.proc_mem_en & ~reset;
   end

   // Port mux: the granted aux agent drives dmem, otherwise the processor.
   // A rejected aux write still takes the grant but never writes.
   always_comb begin
      addr_mux = bus.proc_addr;
      data_mux = bus.proc_data;
      wren_mux = bus.proc_wren & bus.proc_mem_en;
      if (aux_gnt_c) begin
         addr_mux = bus.aux_addr;
         data_mux = bus.aux_data;
         wren_mux = bus.aux_wren & AUX_WR_EN;
      end
      if (reset) begin
         wren_mux = 1'b0;
      end
   end

   // Next starvation count: grows while the processor blocks a waiting
   // request, saturates, and clears on a grant or when nothing is waiting.
   always_comb begin
      starve_cnt_next = starve_cnt;
      if (aux_gnt_c || !bus.aux_req) begin
         starve_cnt_next = '0;
      end else if (bus.proc_mem_en && (starve_cnt != {CNT_W{1'b1}})) begin
         starve_cnt_next = starve_cnt + 1'b1;
      end
   end

   // Read return, write-reject pulse and starvation state. dmem updates
   // mem_q on the falling edge, so a granted read's data is captured at
   // the rising edge that ends the grant cycle. Reset drops any read in
   // flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         err_q      <= 1'b0;
         starve_cnt <= '0;
         starve_q   <= 1'b0;
      end else begin
         rd_valid_q <= aux_gnt_c & ~bus.aux_wren;
         if (aux_gnt_c && !bus.aux_wren) begin
            rd_data_q <= bus.mem_q;
         end
         err_q      <= aux_gnt_c & bus.aux_wren & ~AUX_WR_EN;
         starve_cnt <= starve_cnt_next;
         starve_q   <= (starve_cnt_next >= CNT_W'(STARVE_LIMIT));
      end
   end

   // Output wiring; the processor sees dmem read data unchanged.
   assign bus.aux_gnt      = aux_gnt_c;
   assign bus.mem_addr     = addr_mux;
   assign bus.mem_data     = data_mux;
   assign bus.mem_wren     = wren_mux;
   assign bus.proc_q       = bus.mem_q;
   assign bus.aux_rd_valid = rd_valid_q;
   assign bus.aux_rd_data  = rd_data_q;
   assign bus.aux_err      = err_q;
   assign bus.aux_starve   = starve_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (aux writes enabled and
// disabled), a falling-edge dmem model behind each, directed stimulus and
// an expected-read-data queue drained by an independent monitor.
module tb_dmem_port_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;

   // clock/reset
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
   dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(64),
                       .CNT_W(8), .AUX_WR_EN(1'b1)) u_dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (if0.slave)
   );

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(64),
                       .CNT_W(8), .AUX_WR_EN(1'b0)) u_dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (if1.slave)
   );

   // dmem models, clocked on the falling edge
   logic [DW-1:0] mem0 [0:4095];
   logic [DW-1:0] mem1 [0:4095];

   always @(negedge clock) begin
      if (if0.mem_wren) mem0[if0.mem_addr] <= if0.mem_data;
      if0.mem_q <= mem0[if0.mem_addr];
   end

   always @(negedge clock) begin
      if (if1.mem_wren) mem1[if1.mem_addr] <= if1.mem_data;
      if1.mem_q <= mem1[if1.mem_addr];
   end

   // scoreboard
   logic [DW-1:0] exp_q[$];
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // monitor: every read return of dut0 must match the oldest expectation
   always @(posedge clock) begin
      #4;
      if (if0.aux_rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_unexpected: got data 0x%08h, expected no return",
                     if0.aux_rd_data);
         end else begin
            check("rd_data", if0.aux_rd_data, exp_q.pop_front());
         end
      end
   end

   // driver tasks: inputs change 1 time unit after the rising edge,
   // outputs are sampled 4 units after it (before the dmem falling edge)
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic aux0(input logic req, input logic wren,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
      if0.aux_req  = req;
      if0.aux_wren = wren;
      if0.aux_addr = addr;
      if0.aux_data = data;
   endtask

   task automatic proc0(input logic en, input logic wren,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data);
      if0.proc_mem_en = en;
      if0.proc_wren   = wren;
      if0.proc_addr   = addr;
      if0.proc_data   = data;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem0[i] = '0;
         mem1[i] = '0;
      end
      mem0[12'h010] = 32'hDEADBEEF;
      mem0[12'h005] = 32'h00000055;
      mem0[12'h001] = 32'h00000101;
      mem0[12'h002] = 32'h00000202;
      mem0[12'h003] = 32'h00000303;
      mem1[12'h030] = 32'h00001234;

      proc0(1'b0, 1'b0, 12'h000, 32'h00001111);
      aux0(1'b1, 1'b1, 12'h040, 32'h000000AA);
      if1.proc_mem_en = 1'b0;
      if1.proc_wren   = 1'b0;
      if1.proc_addr   = '0;
      if1.proc_data   = '0;
      if1.aux_req     = 1'b0;
      if1.aux_wren    = 1'b0;
      if1.aux_addr    = '0;
      if1.aux_data    = '0;

      // reset state: aux write pending, grant and write forced low
      step();
      settle();
      check("rst_gnt", 32'(if0.aux_gnt), 32'd0);
      check("rst_mem_wren", 32'(if0.mem_wren), 32'd0);
      check("rst_mem_data", if0.mem_data, 32'h00001111);
      check("rst_rd_valid", 32'(if0.aux_rd_valid), 32'd0);
      check("rst_rd_data", if0.aux_rd_data, 32'd0);
      check("rst_err", 32'(if1.aux_err), 32'd0);
      check("rst_starve", 32'(if0.aux_starve), 32'd0);

      step();
      aux0(1'b0, 1'b0, 12'h000, 32'd0);
      reset = 1'b0;
      settle();

      // single aux read, data back one cycle after the grant
      step();
      aux0(1'b1, 1'b0, 12'h010, 32'd0);
      settle();
      check("rd_gnt", 32'(if0.aux_gnt), 32'd1);
      check("rd_mem_addr", 32'(if0.mem_addr), 32'h010);
      check("rd_mem_wren", 32'(if0.mem_wren), 32'd0);
      exp_q.push_back(32'hDEADBEEF);
      step();
      aux0(1'b0, 1'b0, 12'h000, 32'd0);
      settle();
      check("rd_valid_n1", 32'(if0.aux_rd_valid), 32'd1);
      step();
      settle();
      check("rd_valid_n2", 32'(if0.aux_rd_valid), 32'd0);
      check("rd_data_hold", if0.aux_rd_data, 32'hDEADBEEF);

      // processor store collides with an aux write: processor wins
      step();
      proc0(1'b1, 1'b1, 12'h020, 32'h00000005);
      aux0(1'b1, 1'b1, 12'h020, 32'h00000007);
      settle();
      check("col_gnt", 32'(if0.aux_gnt), 32'd0);
      check("col_mem_data", if0.mem_data, 32'h00000005);
      check("col_mem_wren", 32'(if0.mem_wren), 32'd1);
      check("col_proc_q", if0.proc_q, if0.mem_q);
      step();
      proc0(1'b0, 1'b0, 12'h000, 32'd0);
      settle();
      check("col_aux_gnt", 32'(if0.aux_gnt), 32'd1);
      check("col_aux_data", if0.mem_data, 32'h00000007);
      check("col_aux_wren", 32'(if0.mem_wren), 32'd1);
      step();
      aux0(1'b1, 1'b0, 12'h020, 32'd0);
      settle();
      check("col_mem_final", mem0[12'h020], 32'h00000007);
      check("col_rb_gnt", 32'(if0.aux_gnt), 32'd1);
      exp_q.push_back(32'h00000007);
      step();
      aux0(1'b0, 1'b0, 12'h000, 32'd0);
      settle();

      // starvation: 70 denied cycles, flag rises after the 64th
      step();
      proc0(1'b1, 1'b0, 12'h100, 32'd0);
      aux0(1'b1, 1'b0, 12'h005, 32'd0);
      for (int i = 1; i <= 70; i++) begin
         if (i > 1) step();
         settle();
         if (i == 1)  check("stv_gnt_denied", 32'(if0.aux_gnt), 32'd0);
         if (i == 64) check("stv_before", 32'(if0.aux_starve), 32'd0);
         if (i == 65) check("stv_rise", 32'(if0.aux_starve), 32'd1);
         if (i == 70) check("stv_held", 32'(if0.aux_starve), 32'd1);
      end
      step();
      proc0(1'b0, 1'b0, 12'h000, 32'd0);
      settle();
      check("stv_gnt", 32'(if0.aux_gnt), 32'd1);
      check("stv_still", 32'(if0.aux_starve), 32'd1);
      exp_q.push_back(32'h00000055);
      step();
      aux0(1'b0, 1'b0, 12'h000, 32'd0);
      settle();
      check("stv_clear", 32'(if0.aux_starve), 32'd0);

      // back-to-back reads
      step();
      aux0(1'b1, 1'b0, 12'h001, 32'd0);
      settle();
      check("b2b_gnt1", 32'(if0.aux_gnt), 32'd1);
      exp_q.push_back(32'h00000101);
      step();
      aux0(1'b1, 1'b0, 12'h002, 32'd0);
      settle();
      check("b2b_gnt2", 32'(if0.aux_gnt), 32'd1);
      check("b2b_valid1", 32'(if0.aux_rd_valid), 32'd1);
      exp_q.push_back(32'h00000202);
      step();
      aux0(1'b1, 1'b0, 12'h003, 32'd0);
      settle();
      check("b2b_gnt3", 32'(if0.aux_gnt), 32'd1);
      check("b2b_valid2", 32'(if0.aux_rd_valid), 32'd1);
      exp_q.push_back(32'h00000303);
      step();
      aux0(1'b0, 1'b0, 12'h000, 32'd0);
      settle();
      check("b2b_valid3", 32'(if0.aux_rd_valid), 32'd1);
      step();
      settle();
      check("b2b_valid_end", 32'(if0.aux_rd_valid), 32'd0);

      // reset mid-run: a granted read in flight is dropped
      step();
      aux0(1'b1, 1'b0, 12'h010, 32'd0);
      settle();
      check("mr_gnt_pre", 32'(if0.aux_gnt), 32'd1);
      #2;
      reset = 1'b1;
      step();
      aux0(1'b1, 1'b1, 12'h044, 32'h00000099);
      settle();
      check("mr_gnt", 32'(if0.aux_gnt), 32'd0);
      check("mr_mem_wren", 32'(if0.mem_wren), 32'd0);
      check("mr_rd_valid", 32'(if0.aux_rd_valid), 32'd0);
      step();
      aux0(1'b1, 1'b0, 12'h010, 32'd0);
      settle();
      check("mr_gnt_rd", 32'(if0.aux_gnt), 32'd0);
      check("mr_rd_valid2", 32'(if0.aux_rd_valid), 32'd0);
      step();
      reset = 1'b0;
      settle();
      check("mr_first_gnt", 32'(if0.aux_gnt), 32'd1);
      exp_q.push_back(32'hDEADBEEF);
      step();
      aux0(1'b0, 1'b0, 12'h000, 32'd0);
      settle();
      check("mr_rd_valid_after", 32'(if0.aux_rd_valid), 32'd1);

      // aux writes disabled: granted, not written, error pulse next cycle
      step();
      if1.aux_req  = 1'b1;
      if1.aux_wren = 1'b1;
      if1.aux_addr = 12'h030;
      if1.aux_data = 32'h00000009;
      settle();
      check("we0_gnt", 32'(if1.aux_gnt), 32'd1);
      check("we0_mem_wren", 32'(if1.mem_wren), 32'd0);
      check("we0_err_pre", 32'(if1.aux_err), 32'd0);
      step();
      if1.aux_req = 1'b0;
      settle();
      check("we0_err", 32'(if1.aux_err), 32'd1);
      check("we0_rd_valid", 32'(if1.aux_rd_valid), 32'd0);
      step();
      settle();
      check("we0_err_end", 32'(if1.aux_err), 32'd0);
      check("we0_mem", mem1[12'h030], 32'h00001234);

      step();
      step();
      settle();
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
